// File: rtl/decode_regfile_sb_if.sv
// decode_regfile_sb_if: decode/issue/writeback bundle for the register file.
// master drives read indices, issue request and writeback; slave returns
// read data, stall and pending_any.
interface decode_regfile_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] rs, rt, issue_rd, rd;
   logic use_rs, use_rt, issue_valid, issue_wr, r_write;
   logic [DATA_W-1:0] w_data, dataA, dataB;
   logic stall, pending_any;
   modport master (
      output rs, rt, use_rs, use_rt, issue_valid, issue_wr, issue_rd, r_write, rd, w_data,
      input  dataA, dataB, stall, pending_any
   );
   modport slave (
      input  rs, rt, use_rs, use_rt, issue_valid, issue_wr, issue_rd, r_write, rd, w_data,
      output dataA, dataB, stall, pending_any
   );
endinterface

// File: rtl/decode_regfile_sb.sv
// decode_regfile_sb: decode register file with write-pending scoreboard and issue stall.
// clk/rst: clock and synchronous active-high reset.
// bus (slave): rs/rt/use_rs/use_rt read side, issue_valid/issue_wr/issue_rd issue side,
// r_write/rd/w_data writeback; returns dataA/dataB, stall and registered pending_any.
module decode_regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input logic clk,
   input logic rst,
   decode_regfile_sb_if.slave bus
);
   localparam int N = 2 ** ADDR_W;
   localparam bit Z = (ZERO_REG != 0);
   localparam bit B = (BYPASS != 0);
   logic [DATA_W-1:0] r_regs [N];
   logic [N-1:0] r_pend, w_pend_nxt;
   logic r_pending_any;
   logic w_wr_en, w_set_en, w_byp_a, w_byp_b, w_hz_a, w_hz_b, w_stall;
   assign w_wr_en  = bus.r_write && !(Z && bus.rd == '0);
   assign w_byp_a  = B && bus.r_write && bus.rd == bus.rs;
   assign w_byp_b  = B && bus.r_write && bus.rd == bus.rt;
   // pend[0] never sets under ZERO_REG, so r0 needs no explicit hazard mask
   assign w_hz_a   = r_pend[bus.rs] && !w_byp_a;
   assign w_hz_b   = r_pend[bus.rt] && !w_byp_b;
   assign w_stall  = bus.issue_valid && ((bus.use_rs && w_hz_a) || (bus.use_rt && w_hz_b));
   assign w_set_en = bus.issue_valid && !w_stall && bus.issue_wr && !(Z && bus.issue_rd == '0);
   assign bus.dataA = (Z && bus.rs == '0) ? '0 : w_byp_a ? bus.w_data : r_regs[bus.rs];
   assign bus.dataB = (Z && bus.rt == '0) ? '0 : w_byp_b ? bus.w_data : r_regs[bus.rt];
   assign bus.stall = w_stall;
   assign bus.pending_any = r_pending_any;
   // set is applied after clear so a same-index issue re-marks the register
   always_comb begin
      w_pend_nxt = r_pend;
      if (w_wr_en) w_pend_nxt[bus.rd] = 1'b0;
      if (w_set_en) w_pend_nxt[bus.issue_rd] = 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) r_regs[i] <= '0;
         r_pend <= '0;
         r_pending_any <= 1'b0;
      end else begin
         if (w_wr_en) r_regs[bus.rd] <= bus.w_data;
         r_pend <= w_pend_nxt;
         r_pending_any <= |w_pend_nxt;
      end
   end
endmodule
